// File: rtl/adsr_pkg.sv
// Shared types and defaults for the adsr_bank envelope generator.
package adsr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_e;

  localparam int DEF_NUM_VOICES = 16;
  localparam int DEF_LEVEL_W    = 16;
  localparam int DEF_TICK_DIV   = 50000;
  localparam logic [DEF_LEVEL_W-1:0] LEVEL_MAX = {DEF_LEVEL_W{1'b1}};

endpackage

// File: rtl/adsr_bank_if.sv
// Gate/parameter/envelope bus between the note sequencer (master) and adsr_bank (slave).
interface adsr_bank_if #(
  parameter int NUM_VOICES = 16,
  parameter int LEVEL_W    = 16
);
  logic [NUM_VOICES-1:0]         trigger;
  logic [LEVEL_W-1:0]            attack_rate;
  logic [LEVEL_W-1:0]            decay_rate;
  logic [LEVEL_W-1:0]            sustain_level;
  logic [LEVEL_W-1:0]            release_rate;
  logic                          param_load;
  logic [NUM_VOICES*LEVEL_W-1:0] env_flat;
  logic [NUM_VOICES-1:0]         voice_active;
  logic                          update_done;

  modport master (
    output trigger, attack_rate, decay_rate, sustain_level, release_rate, param_load,
    input  env_flat, voice_active, update_done
  );

  modport slave (
    input  trigger, attack_rate, decay_rate, sustain_level, release_rate, param_load,
    output env_flat, voice_active, update_done
  );
endinterface

// File: rtl/adsr_voice_step.sv
// Combinational per-slot envelope update shared by every voice of adsr_bank.
// Arithmetic is one bit wider than the level so overflow/underflow saturates instead of wrapping.
module adsr_voice_step
  import adsr_pkg::*;
#(
  parameter int LEVEL_W = DEF_LEVEL_W
) (
  input  adsr_state_e        i_state,
  input  logic [LEVEL_W-1:0] i_level,
  input  logic               i_gate,
  input  logic               i_pending,
  input  logic [LEVEL_W-1:0] i_attack_rate,
  input  logic [LEVEL_W-1:0] i_decay_rate,
  input  logic [LEVEL_W-1:0] i_sustain_level,
  input  logic [LEVEL_W-1:0] i_release_rate,
  output adsr_state_e        o_state,
  output logic [LEVEL_W-1:0] o_level
);

  localparam logic [LEVEL_W-1:0] MAX_L  = {LEVEL_W{1'b1}};
  localparam logic [LEVEL_W-1:0] ZERO_L = {LEVEL_W{1'b0}};

  logic [LEVEL_W:0]   w_sum;
  logic [LEVEL_W:0]   w_dec;
  logic [LEVEL_W:0]   w_rel;
  logic               w_att_sat;
  logic [LEVEL_W-1:0] w_att_level;
  adsr_state_e        w_att_state;
  logic               w_dec_hit;
  logic               w_rel_hit;

  always_comb begin
    w_sum       = {1'b0, i_level} + {1'b0, i_attack_rate};
    w_dec       = {1'b0, i_level} - {1'b0, i_decay_rate};
    w_rel       = {1'b0, i_level} - {1'b0, i_release_rate};
    // A zero rate is an immediate step to the target.
    w_att_sat   = (i_attack_rate == ZERO_L) || w_sum[LEVEL_W] || (w_sum[LEVEL_W-1:0] == MAX_L);
    w_att_level = w_att_sat ? MAX_L : w_sum[LEVEL_W-1:0];
    w_att_state = w_att_sat ? ST_DECAY : ST_ATTACK;
    w_dec_hit   = (i_decay_rate == ZERO_L) || w_dec[LEVEL_W] ||
                  (w_dec[LEVEL_W-1:0] <= i_sustain_level);
    w_rel_hit   = (i_release_rate == ZERO_L) || w_rel[LEVEL_W] ||
                  (w_rel[LEVEL_W-1:0] == ZERO_L);
  end

  always_comb begin
    o_state = i_state;
    o_level = i_level;
    case (i_state)
      ST_IDLE: begin
        if (i_gate) begin
          o_state = w_att_state;
          o_level = w_att_level;
        end else begin
          o_state = ST_IDLE;
        end
      end
      ST_ATTACK: begin
        if (!i_gate) begin
          o_state = ST_RELEASE;
        end else begin
          o_state = w_att_state;
          o_level = w_att_level;
        end
      end
      ST_DECAY: begin
        if (!i_gate) begin
          o_state = ST_RELEASE;
        end else if (i_pending) begin
          o_state = w_att_state;
          o_level = w_att_level;
        end else if (w_dec_hit) begin
          o_state = ST_SUSTAIN;
          o_level = i_sustain_level;
        end else begin
          o_level = w_dec[LEVEL_W-1:0];
        end
      end
      ST_SUSTAIN: begin
        if (!i_gate) begin
          o_state = ST_RELEASE;
        end else if (i_pending) begin
          o_state = w_att_state;
          o_level = w_att_level;
        end else begin
          o_level = i_sustain_level;
        end
      end
      ST_RELEASE: begin
        if (i_gate) begin
          o_state = w_att_state;
          o_level = w_att_level;
        end else if (w_rel_hit) begin
          o_state = ST_IDLE;
          o_level = ZERO_L;
        end else begin
          o_level = w_rel[LEVEL_W-1:0];
        end
      end
      default: begin
        o_state = ST_IDLE;
        o_level = ZERO_L;
      end
    endcase
  end

endmodule

// File: rtl/adsr_bank.sv
// Multi-voice ADSR envelope bank: one shared step datapath swept across all voices every tick.
// Optional macro ADSR_RETRIG_EN latches trigger rising edges so short retrigger pulses re-attack.
module adsr_bank
  import adsr_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int LEVEL_W    = DEF_LEVEL_W,
  parameter int TICK_DIV   = DEF_TICK_DIV
) (
  input logic        clk,
  input logic        reset,
  adsr_bank_if.slave bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [CNT_W-1:0]              r_tick_cnt;
  logic                          r_sweep_active;
  logic [IDX_W-1:0]              r_idx;
  logic [LEVEL_W-1:0]            r_sh_attack, r_sh_decay, r_sh_sustain, r_sh_release;
  logic [LEVEL_W-1:0]            r_wk_attack, r_wk_decay, r_wk_sustain, r_wk_release;
  adsr_state_e                   r_state [NUM_VOICES];
  logic [NUM_VOICES*LEVEL_W-1:0] r_env_flat;
  logic [NUM_VOICES-1:0]         r_voice_active;
  logic                          r_update_done;

  logic                          w_wrap;
  logic                          w_last;
  logic                          w_pending;
  adsr_state_e                   w_next_state;
  logic [LEVEL_W-1:0]            w_next_level;

  assign w_wrap = (r_tick_cnt == CNT_W'(TICK_DIV - 1));
  assign w_last = (r_idx == IDX_W'(NUM_VOICES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt     <= {CNT_W{1'b0}};
      r_sweep_active <= 1'b0;
      r_idx          <= {IDX_W{1'b0}};
      r_update_done  <= 1'b0;
      r_sh_attack    <= {LEVEL_W{1'b0}};
      r_sh_decay     <= {LEVEL_W{1'b0}};
      r_sh_sustain   <= {LEVEL_W{1'b0}};
      r_sh_release   <= {LEVEL_W{1'b0}};
      r_wk_attack    <= {LEVEL_W{1'b0}};
      r_wk_decay     <= {LEVEL_W{1'b0}};
      r_wk_sustain   <= {LEVEL_W{1'b0}};
      r_wk_release   <= {LEVEL_W{1'b0}};
    end else begin
      r_update_done <= r_sweep_active && w_last;
      if (bus.param_load) begin
        r_sh_attack  <= bus.attack_rate;
        r_sh_decay   <= bus.decay_rate;
        r_sh_sustain <= bus.sustain_level;
        r_sh_release <= bus.release_rate;
      end
      // Working params change only at the wrap, so a sweep never sees a mix of old and new.
      if (w_wrap) begin
        r_tick_cnt     <= {CNT_W{1'b0}};
        r_wk_attack    <= r_sh_attack;
        r_wk_decay     <= r_sh_decay;
        r_wk_sustain   <= r_sh_sustain;
        r_wk_release   <= r_sh_release;
        r_sweep_active <= 1'b1;
        r_idx          <= {IDX_W{1'b0}};
      end else begin
        r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        if (r_sweep_active) begin
          if (w_last) begin
            r_sweep_active <= 1'b0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
      end
    end
  end

`ifdef ADSR_RETRIG_EN
  logic [NUM_VOICES-1:0] r_trig_d;
  logic [NUM_VOICES-1:0] r_pending;
  logic [NUM_VOICES-1:0] w_slot_mask;

  always_comb begin
    w_slot_mask = {NUM_VOICES{1'b0}};
    if (r_sweep_active) begin
      w_slot_mask[r_idx] = 1'b1;
    end else begin
      w_slot_mask = {NUM_VOICES{1'b0}};
    end
  end

  // A new edge wins over the slot clear so it is serviced on the following tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_trig_d  <= {NUM_VOICES{1'b0}};
      r_pending <= {NUM_VOICES{1'b0}};
    end else begin
      r_trig_d  <= bus.trigger;
      r_pending <= (r_pending & ~w_slot_mask) | (bus.trigger & ~r_trig_d);
    end
  end

  assign w_pending = r_pending[r_idx];
`else
  assign w_pending = 1'b0;
`endif

  adsr_voice_step #(.LEVEL_W(LEVEL_W)) u_step (
    .i_state         (r_state[r_idx]),
    .i_level         (r_env_flat[r_idx*LEVEL_W +: LEVEL_W]),
    .i_gate          (bus.trigger[r_idx]),
    .i_pending       (w_pending),
    .i_attack_rate   (r_wk_attack),
    .i_decay_rate    (r_wk_decay),
    .i_sustain_level (r_wk_sustain),
    .i_release_rate  (r_wk_release),
    .o_state         (w_next_state),
    .o_level         (w_next_level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_state[i] <= ST_IDLE;
      end
      r_env_flat     <= {(NUM_VOICES*LEVEL_W){1'b0}};
      r_voice_active <= {NUM_VOICES{1'b0}};
    end else if (r_sweep_active) begin
      r_state[r_idx]                        <= w_next_state;
      r_env_flat[r_idx*LEVEL_W +: LEVEL_W]  <= w_next_level;
      r_voice_active[r_idx]                 <= (w_next_state != ST_IDLE);
    end
  end

  assign bus.env_flat     = r_env_flat;
  assign bus.voice_active = r_voice_active;
  assign bus.update_done  = r_update_done;

endmodule

// File: tb/tb_adsr_bank.sv
// Directed self-checking bench for adsr_bank (16 voices, 16-bit levels, 64-cycle tick).
module tb_adsr_bank;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  adsr_bank_if #(.NUM_VOICES(16), .LEVEL_W(16)) bus ();

  adsr_bank #(.NUM_VOICES(16), .LEVEL_W(16), .TICK_DIV(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lvl(input int v);
    return bus.env_flat[v*16 +: 16];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns on the negedge where update_done is high (tick counter = 16).
  task automatic wait_sweep();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.update_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("sweep_timeout", {31'd0, seen}, 32'd1);
  endtask

  logic [15:0] att_exp [4];
  logic [15:0] dec_exp [8];
  logic [15:0] rel_exp [5];
  logic        rel_act [5];
  logic [15:0] retrig_exp;
  int          pulses;

  initial begin
    checks   = 0;
    failures = 0;
    att_exp = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
    dec_exp = '{16'hEFFF, 16'hDFFF, 16'hCFFF, 16'hBFFF, 16'hAFFF, 16'h9FFF, 16'h8FFF, 16'h8000};
    rel_exp = '{16'h8000, 16'h6000, 16'h4000, 16'h2000, 16'h0000};
    rel_act = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef ADSR_RETRIG_EN
    retrig_exp = 16'hC000;
`else
    retrig_exp = 16'h8000;
`endif

    reset             = 1'b0;
    bus.trigger       = 16'h0000;
    bus.attack_rate   = 16'h0000;
    bus.decay_rate    = 16'h0000;
    bus.sustain_level = 16'h0000;
    bus.release_rate  = 16'h0000;
    bus.param_load    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_env", {31'd0, |bus.env_flat}, 32'd0);
    check("reset_active", {16'd0, bus.voice_active}, 32'd0);
    check("reset_done", {31'd0, bus.update_done}, 32'd0);

    reset             = 1'b1;
    bus.attack_rate   = 16'h4000;
    bus.decay_rate    = 16'h1000;
    bus.sustain_level = 16'h8000;
    bus.release_rate  = 16'h2000;
    bus.param_load    = 1'b1;
    @(negedge clk);
    bus.param_load    = 1'b0;
    wait_sweep();
    check("idle_tick0_active", {16'd0, bus.voice_active}, 32'd0);

    // Attack on voices 3 and 5.
    bus.trigger[3] = 1'b1;
    bus.trigger[5] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_sweep();
      check($sformatf("attack_v3_t%0d", k + 1), {16'd0, lvl(3)}, {16'd0, att_exp[k]});
      check("attack_v3_active", {31'd0, bus.voice_active[3]}, 32'd1);
    end
    check("attack_v5", {16'd0, lvl(5)}, 32'h0000FFFF);
    check("attack_v2_untouched", {16'd0, lvl(2)}, 32'd0);

    for (int k = 0; k < 8; k++) begin
      wait_sweep();
      check($sformatf("decay_v3_t%0d", k + 1), {16'd0, lvl(3)}, {16'd0, dec_exp[k]});
    end

    // Sustain hold; a 2-cycle low pulse on voice 5 between ticks.
    for (int h = 0; h < 10; h++) begin
      wait_sweep();
      check($sformatf("sustain_v3_h%0d", h + 1), {16'd0, lvl(3)}, 32'h00008000);
      if (h == 3) begin
        @(negedge clk);
        bus.trigger[5] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.trigger[5] = 1'b1;
      end
      if (h == 4) begin
        check("retrig_v5", {16'd0, lvl(5)}, {16'd0, retrig_exp});
        bus.trigger[5] = 1'b0;
      end
    end

    pulses = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bus.update_done === 1'b1) pulses++;
    end
    check("done_once_per_64", pulses, 32'd1);
    check("sustain_v3_after_window", {16'd0, lvl(3)}, 32'h00008000);

    bus.trigger[3] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_sweep();
      check($sformatf("release_v3_t%0d", k), {16'd0, lvl(3)}, {16'd0, rel_exp[k]});
      check($sformatf("release_v3_act%0d", k), {31'd0, bus.voice_active[3]}, {31'd0, rel_act[k]});
    end

    // param_load in the wrap cycle: that tick still uses attack_rate 0x4000.
    bus.trigger[7] = 1'b1;
    repeat (47) @(negedge clk);
    bus.attack_rate = 16'h0000;
    bus.param_load  = 1'b1;
    @(negedge clk);
    bus.param_load  = 1'b0;
    wait_sweep();
    check("wrap_load_old_value_v7", {16'd0, lvl(7)}, 32'h00004000);
    bus.trigger[8] = 1'b1;
    wait_sweep();
    check("rate0_attack_v7", {16'd0, lvl(7)}, 32'h0000FFFF);
    check("rate0_attack_v8", {16'd0, lvl(8)}, 32'h0000FFFF);
    check("rate0_active_v8", {31'd0, bus.voice_active[8]}, 32'd1);
    wait_sweep();
    check("decay_after_rate0_v8", {16'd0, lvl(8)}, 32'h0000EFFF);

    // Asynchronous reset in the middle of a sweep.
    wait_sweep();
    repeat (53) @(negedge clk);
    check("pre_reset_active_v7", {31'd0, bus.voice_active[7]}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_reset_env", {31'd0, |bus.env_flat}, 32'd0);
    check("async_reset_active", {16'd0, bus.voice_active}, 32'd0);
    check("async_reset_done", {31'd0, bus.update_done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
